// File: rtl/debounce_pkg.sv
// Shared types and defaults for the input debounce filter.
// Also holds the state encoding used by the FSM in debounce_filter.
package debounce_pkg;

    typedef enum logic [1:0] {
        LOW      = 2'd0,
        RISE_CHK = 2'd1,
        HIGH     = 2'd2,
        FALL_CHK = 2'd3
    } state_t;

    localparam int DEFAULT_SYNC_STAGES     = 2;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchroniser for a single asynchronous bit.
// Reused for every async input that enters the clk domain.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/debounce_filter.sv
// Synchronises and debounces a bouncy input into a clean level,
// counting rejected transitions for diagnostics.
module debounce_filter
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int GLITCH_W        = 8
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                din,
    input  logic                glitch_clr,
    output logic                dout,
    output logic                stable,
    output logic [GLITCH_W-1:0] glitch_count
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          din_s;
    logic          reject;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (din),
        .q      (din_s)
    );

    // Input fell back to the old level while a transition was being checked
    assign reject = ((state == RISE_CHK) && !din_s) ||
                    ((state == FALL_CHK) &&  din_s);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state  <= LOW;
            cnt    <= '0;
            dout   <= 1'b0;
            stable <= 1'b1;
        end else begin
            unique case (state)
                LOW: begin
                    if (din_s) begin
                        state  <= RISE_CHK;
                        cnt    <= CW'(1);
                        stable <= 1'b0;
                    end
                end
                RISE_CHK: begin
                    if (!din_s) begin
                        state  <= LOW;
                        cnt    <= '0;
                        stable <= 1'b1;
                    end else if (cnt == CNT_LAST) begin
                        state  <= HIGH;
                        cnt    <= '0;
                        dout   <= 1'b1;
                        stable <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                HIGH: begin
                    if (!din_s) begin
                        state  <= FALL_CHK;
                        cnt    <= CW'(1);
                        stable <= 1'b0;
                    end
                end
                FALL_CHK: begin
                    if (din_s) begin
                        state  <= HIGH;
                        cnt    <= '0;
                        stable <= 1'b1;
                    end else if (cnt == CNT_LAST) begin
                        state  <= LOW;
                        cnt    <= '0;
                        dout   <= 1'b0;
                        stable <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state  <= LOW;
                    cnt    <= '0;
                    dout   <= 1'b0;
                    stable <= 1'b1;
                end
            endcase
        end
    end

    // Clear takes priority over a coincident rejection
    always_ff @(posedge clk) begin
        if (!resetn) begin
            glitch_count <= '0;
        end else if (glitch_clr) begin
            glitch_count <= '0;
        end else if (reject && (glitch_count != '1)) begin
            glitch_count <= glitch_count + GLITCH_W'(1);
        end
    end

endmodule

// File: tb/tb_debounce_filter.sv
// Scoreboard bench for debounce_filter: default instance plus a
// GLITCH_W=2 instance sharing the same stimulus for saturation.
module tb_debounce_filter;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       din = 1'b0;
    logic       glitch_clr = 1'b0;
    logic       dout;
    logic       stable;
    logic [7:0] glitch_count;
    logic       dout2;
    logic       stable2;
    logic [1:0] glitch_count2;

    debounce_filter u_dut (
        .clk          (clk),
        .resetn       (resetn),
        .din          (din),
        .glitch_clr   (glitch_clr),
        .dout         (dout),
        .stable       (stable),
        .glitch_count (glitch_count)
    );

    debounce_filter #(
        .GLITCH_W (2)
    ) u_dut2 (
        .clk          (clk),
        .resetn       (resetn),
        .din          (din),
        .glitch_clr   (glitch_clr),
        .dout         (dout2),
        .stable       (stable2),
        .glitch_count (glitch_count2)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        string      name;
        logic       d;
        logic       s;
        logic [7:0] g;
        logic [1:0] g2;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    // Monitor: after each rising edge, check every expectation due now
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            #1;
            while (q.size() > 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                tests = tests + 4;
                if (dout !== e.d) begin
                    fails = fails + 1;
                    $display("FAIL %s cyc=%0d dout got %b want %b",
                             e.name, cyc, dout, e.d);
                end
                if (stable !== e.s) begin
                    fails = fails + 1;
                    $display("FAIL %s cyc=%0d stable got %b want %b",
                             e.name, cyc, stable, e.s);
                end
                if (glitch_count !== e.g) begin
                    fails = fails + 1;
                    $display("FAIL %s cyc=%0d glitch_count got %0d want %0d",
                             e.name, cyc, glitch_count, e.g);
                end
                if (glitch_count2 !== e.g2) begin
                    fails = fails + 1;
                    $display("FAIL %s cyc=%0d glitch_count(W=2) got %0d want %0d",
                             e.name, cyc, glitch_count2, e.g2);
                end
            end
        end
    end

    // Drive inputs for the next edge and queue the values expected after it
    task automatic step(input int d, input int c, input int r,
                        input int ed, input int es, input int eg,
                        input int eg2, input string nm);
        exp_t e;
        @(negedge clk);
        din        = d[0];
        glitch_clr = c[0];
        resetn     = r[0];
        e.cyc  = cyc + 1;
        e.name = nm;
        e.d    = ed[0];
        e.s    = es[0];
        e.g    = eg[7:0];
        e.g2   = eg2[1:0];
        q.push_back(e);
    endtask

    initial begin
        logic [9:0] bp;
        int g;
        bp = 10'b0000011011;

        repeat (2) step(0, 0, 0, 0, 1, 0, 0, "reset");
        for (int i = 0; i < 20; i++)
            step(0, 0, 1, 0, 1, 0, 0, "idle");

        for (int i = 1; i <= 8; i++)
            step(1, 0, 1, (i >= 6) ? 1 : 0,
                 (i >= 3 && i <= 5) ? 0 : 1, 0, 0, "rise");
        for (int i = 1; i <= 8; i++)
            step(0, 0, 1, (i >= 6) ? 0 : 1,
                 (i >= 3 && i <= 5) ? 0 : 1, 0, 0, "fall");

        for (int i = 0; i < 10; i++) begin
            g = (i >= 7) ? 2 : ((i >= 4) ? 1 : 0);
            step(bp[i] ? 1 : 0, 0, 1, 0,
                 (i == 2 || i == 3 || i == 5 || i == 6) ? 0 : 1,
                 g, g, "bounce");
        end

        step(0, 1, 1, 0, 1, 0, 0, "clr");

        for (int p = 0; p < 5; p++) begin
            for (int s = 0; s < 4; s++) begin
                g = (s == 3) ? p + 1 : p;
                step((s == 0) ? 1 : 0, 0, 1, 0, (s == 2) ? 0 : 1,
                     g, (g > 3) ? 3 : g, "saturate");
            end
        end

        step(1, 0, 1, 0, 1, 5, 3, "clr_vs_glitch");
        step(0, 0, 1, 0, 1, 5, 3, "clr_vs_glitch");
        step(0, 0, 1, 0, 0, 5, 3, "clr_vs_glitch");
        step(0, 1, 1, 0, 1, 0, 0, "clr_vs_glitch");

        step(1, 0, 1, 0, 1, 0, 0, "rst_mid_pre");
        step(1, 0, 1, 0, 1, 0, 0, "rst_mid_pre");
        step(1, 0, 1, 0, 0, 0, 0, "rst_mid_pre");
        step(1, 0, 0, 0, 1, 0, 0, "rst_mid");
        for (int i = 1; i <= 8; i++)
            step(1, 0, 1, (i >= 6) ? 1 : 0,
                 (i >= 3 && i <= 5) ? 0 : 1, 0, 0, "rst_release");

        repeat (3) @(posedge clk);
        #2;
        tests = tests + 1;
        if (q.size() != 0) begin
            fails = fails + 1;
            $display("FAIL drain pending got %0d want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/debounce_filter.md
Name: debounce_filter

Overview:
- Conditions a raw, asynchronous, bouncy 1-bit input into a clean, glitch-free level.
- Sits directly upstream of the rising-edge pulse detector and drives that stage's din.
- Contains a multi-flop synchroniser, then a 4-state debounce FSM with a stability counter, plus a saturating glitch counter for diagnostics.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops; legal range >= 2.
- DEBOUNCE_CYCLES, 4, consecutive synchronised samples at the new level required to accept a transition; legal range >= 2.
- GLITCH_W, 8, width of the saturating glitch counter.

Ports:
- clk  input  1  clock, rising edge.
- resetn  input  1  synchronous, active-low reset.
- din  input  1  raw asynchronous input.
- glitch_clr  input  1  synchronous clear of glitch_count (registered domain).
- dout  output  1  debounced level; feeds the edge detector.
- stable  output  1  1 when the FSM is in a settled state (LOW/HIGH).
- glitch_count  output  GLITCH_W  count of rejected transitions, saturating.

Behaviour:
- Reset: reset is clk = synchronous, resetn = active-low. With resetn=0 at a rising edge, on that edge:
  - all sync flops = 0
  - state = LOW, dout = 0, stable = 1
  - stability counter = 0, glitch_count = 0
- Reset asserted mid-operation aborts any check in progress. No pending transition survives reset.
- Synchroniser: din_s is the output of the last of SYNC_STAGES flops. The FSM sees only din_s.
- Counter width: cnt is $clog2(DEBOUNCE_CYCLES+1) bits.
- State LOW (dout=0, stable=1):
  - din_s=1: go to RISE_CHK, cnt<=1.
  - otherwise hold.
- State RISE_CHK (dout=0, stable=0):
  - din_s=0: go to LOW, cnt<=0, glitch_count increments.
  - else if cnt==DEBOUNCE_CYCLES-1: go to HIGH, dout<=1, cnt<=0.
  - else cnt<=cnt+1.
- State HIGH (dout=1, stable=1):
  - din_s=0: go to FALL_CHK, cnt<=1.
- State FALL_CHK (dout=1, stable=0):
  - din_s=1: go to HIGH, cnt<=0, glitch_count increments.
  - else if cnt==DEBOUNCE_CYCLES-1: go to LOW, dout<=0, cnt<=0.
  - else cnt<=cnt+1.
- Outputs: dout and stable are registered and are pure functions of state.
- Latency: dout changes on the (SYNC_STAGES+DEBOUNCE_CYCLES)-th rising edge at which din is held at the new level. The first sampling edge counts as 1. Defaults give 6 edges.
- Rejection rule: any return of din_s to the old level during a CHK state rejects the transition. The counter restarts from scratch on the next attempt.
- glitch_count saturates at 2^GLITCH_W-1 and never wraps.
- glitch_clr=1 sets glitch_count to 0 on that edge. If it coincides with a glitch increment, the clear wins.
- The FSM stays in the settled state while din_s matches dout. cnt stays 0 there.
- Illegal/unreachable state encodings recover to LOW with dout=0 on the next edge.

Decomposition:
- Package debounce_pkg:
  - typedef enum logic [1:0] state_t {LOW, RISE_CHK, HIGH, FALL_CHK}
  - localparam DEFAULT_SYNC_STAGES=2, DEFAULT_DEBOUNCE_CYCLES=4
- Sub-module sync_chain (parameter STAGES; ports clk, resetn, d, q). It is reused by other async inputs in the design.
- FSM, stability counter and glitch counter stay in debounce_filter.

Test Plan:
- Reset, then din=0 for 20 cycles -> dout=0, stable=1, glitch_count=0 throughout.
- Clean rise: din 0->1 held (defaults) -> dout=1 exactly on the 6th sampling edge. stable=0 for the 3 cycles before it, then 1. Symmetric check for the 1->0 fall.
- Bounce: din high for 2 cycles, low 1, high 2, low 1 (defaults), then stays low -> dout stays 0 and glitch_count=2.
- Saturation: GLITCH_W=2, generate 5 rejected pulses -> glitch_count reads 1,2,3,3,3.
- glitch_clr asserted on the same edge as a rejection -> glitch_count=0 after that edge.
- Reset mid-check: din held high, resetn=0 on the 4th sampling edge, released with din still high -> dout=0 immediately. dout then rises on the 6th sampling edge after release.
